// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver:
// controller state encoding and the hex digit -> segment pattern table.
package seven_seg_pkg;

    // Capture/conversion controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Segment patterns {dp,g,f,e,d,c,b,a}, active-high, indexed by digit 0..F.
    // Entry 0 sits in the least significant byte; dp is never lit.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39,   // F E D C
        8'h7C, 8'h77, 8'h6F, 8'h7F,   // B A 9 8
        8'h07, 8'h7D, 8'h6D, 8'h66,   // 7 6 5 4
        8'h4F, 8'h5B, 8'h06, 8'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational 4-bit digit to seven-segment pattern lookup.
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] segments
);

    // Every 4-bit code has a table entry, so no default handling is needed.
    assign segments = SEG_TABLE[digit];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment display driver.
// A Load captures a value and formats it either as hex nibbles (one cycle)
// or as BCD via a serial double-dabble converter (VALUE_WIDTH cycles). The
// result is committed atomically into the display register, which a
// free-running prescaler scans one digit at a time.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 16,
    parameter int SCAN_DIV    = 1000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [VALUE_WIDTH-1:0] Value,
    input  logic                   Load,
    input  logic                   DecimalMode,
    input  logic                   BlankLeading,
    output logic                   Busy,
    output logic                   Overflow,
    output logic [7:0]             Segments,
    output logic [NUM_DIGITS-1:0]  DigitEnable
);

    localparam int DISP_W     = 4 * NUM_DIGITS;
    // Each BCD digit absorbs more than 3 binary bits, so W/3+1 digits
    // always hold the full decimal expansion of a W-bit value.
    localparam int BCD_DIGITS = VALUE_WIDTH / 3 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(VALUE_WIDTH + 1);
    localparam int PRE_W      = $clog2(SCAN_DIV);
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    state_t                       state;
    logic [VALUE_WIDTH-1:0]       bin_sr;      // captured value / shift source
    logic [BCD_W-1:0]             bcd;         // BCD accumulator
    logic [BCD_W-1:0]             bcd_adj;     // accumulator after add-3 step
    logic [CNT_W-1:0]             iter_cnt;    // remaining double-dabble iterations
    logic                         dec_mode;    // captured DecimalMode
    logic                         blank_pend;  // captured BlankLeading, not yet shown

    logic [NUM_DIGITS-1:0][3:0]   digits;      // committed display digits
    logic                         blank_cap;   // committed BlankLeading
    logic [NUM_DIGITS-1:0][7:0]   digit_seg;   // encoded pattern per digit
    logic [IDX_W-1:0]             top_nz;      // most significant non-zero digit

    logic [PRE_W-1:0]             presc;
    logic [IDX_W-1:0]             idx;

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Capture/convert/commit controller; the display only changes in COMMIT,
    // so a reset mid-conversion leaves no partial result behind.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            Busy       <= 1'b0;
            Overflow   <= 1'b0;
            bin_sr     <= '0;
            bcd        <= '0;
            iter_cnt   <= '0;
            dec_mode   <= 1'b0;
            blank_pend <= 1'b0;
            digits     <= '0;
            blank_cap  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Load) begin
                        bin_sr     <= Value;
                        bcd        <= '0;
                        iter_cnt   <= CNT_W'(VALUE_WIDTH - 1);
                        dec_mode   <= DecimalMode;
                        blank_pend <= BlankLeading;
                        Busy       <= 1'b1;
                        state      <= DecimalMode ? ST_CONVERT : ST_COMMIT;
                    end
                end
                ST_CONVERT: begin
                    // Shift the binary MSB into the corrected BCD accumulator.
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    iter_cnt      <= iter_cnt - CNT_W'(1);
                    if (iter_cnt == '0) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (dec_mode) begin
                        digits   <= DISP_W'(bcd);
                        Overflow <= (bcd >> DISP_W) != '0;
                    end else begin
                        digits   <= DISP_W'(bin_sr);
                        Overflow <= 1'b0;
                    end
                    blank_cap <= blank_pend;
                    Busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // One encoder per digit position; the scan mux picks the active one.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seven_seg_encoder u_enc (
            .digit    (digits[g]),
            .segments (digit_seg[g])
        );
    end

    // Locate the highest non-zero digit; digit 0 is the floor so it is never blanked.
    always_comb begin
        top_nz = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (digits[i] != 4'd0) begin
                top_nz = IDX_W'(i);
            end
        end
    end

    // Prescaler and digit index: each digit is enabled for SCAN_DIV cycles.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    // Registered outputs; blanked digits keep their enable so scan timing is uniform.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Segments    <= 8'h00;
            DigitEnable <= '0;
        end else begin
            Segments    <= (blank_cap && (idx > top_nz)) ? 8'h00 : digit_seg[idx];
            DigitEnable <= NUM_DIGITS'(1) << idx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: directed cases plus
// randomized loads, compared against an arithmetic model of the display.
module tb_seven_seg_scan_driver;

    localparam int N  = 4;
    localparam int VW = 16;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic          dec = 1'b0;
    logic          blank = 1'b0;
    logic [VW-1:0] value = '0;
    logic          busy;
    logic          ovf;
    logic [7:0]    seg;
    logic [N-1:0]  en;

    int checks = 0;
    int errors = 0;
    int k = 0;                 // rising edges since reset release

    // Model of what the display is currently committed to.
    int unsigned m_val = 0;
    bit          m_dec = 1'b0;
    bit          m_blank = 1'b0;

    logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seven_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .VALUE_WIDTH (VW),
        .SCAN_DIV    (SD)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Value        (value),
        .Load         (load),
        .DecimalMode  (dec),
        .BlankLeading (blank),
        .Busy         (busy),
        .Overflow     (ovf),
        .Segments     (seg),
        .DigitEnable  (en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mdig(input int i);
        if (m_dec) return int'((m_val / (10 ** i)) % 10);
        return int'((m_val >> (4 * i)) & 15);
    endfunction

    function automatic logic [7:0] exp_seg(input int i);
        int top = 0;
        for (int j = 1; j < N; j++) if (mdig(j) != 0) top = j;
        if (m_blank && i > top) return 8'h00;
        return tbl[mdig(i)];
    endfunction

    // Scan position follows purely from elapsed cycles since reset release.
    task automatic scan_check();
        int pos;
        if (k == 0) begin
            chk("enable_before_scan", 32'(en), 32'(0));
            chk("segments_before_scan", 32'(seg), 32'(0));
        end else begin
            pos = ((k - 1) / SD) % N;
            chk($sformatf("digit_enable k=%0d", k), 32'(en), 32'(1 << pos));
            chk($sformatf("segments digit%0d k=%0d", pos, k), 32'(seg), 32'(exp_seg(pos)));
        end
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_check();
            chk("busy_idle", 32'(busy), 32'(0));
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_overflow", 32'(ovf), 32'(0));
        chk("reset_segments", 32'(seg), 32'(0));
        chk("reset_enable", 32'(en), 32'(0));
        rst     = 1'b0;
        m_val   = 0;
        m_dec   = 1'b0;
        m_blank = 1'b0;
    endtask

    // Issue one load (caller is at a negedge with Busy low); optionally pulse
    // a conflicting Load at busy cycle intr, which must be ignored.
    task automatic run_load(input int unsigned v, input bit d, input bit b, input int intr);
        int busy_cyc = 0;
        bit done = 1'b0;
        value = VW'(v);
        dec   = d;
        blank = b;
        load  = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            scan_check();
            load = 1'b0;
            if (busy) begin
                busy_cyc++;
                if (c == intr) begin
                    load  = 1'b1;
                    value = ~value;
                    dec   = ~d;
                    blank = ~b;
                end
            end else begin
                done = 1'b1;
            end
        end
        chk("busy_released", 32'(done), 32'(1));
        chk($sformatf("busy_cycles v=%0h dec=%0d", v, d), 32'(busy_cyc), 32'(d ? VW + 1 : 1));
        chk($sformatf("overflow v=%0h dec=%0d", v, d), 32'(ovf),
            32'((d && v >= 10 ** N) ? 1 : 0));
        m_val   = v;
        m_dec   = d;
        m_blank = b;
    endtask

    initial begin
        do_reset();
        scan(2 * N * SD);

        run_load(32'h0052, 1'b0, 1'b0, -1);
        scan(N * SD + 2);
        run_load(32'h0052, 1'b1, 1'b0, -1);
        scan(N * SD + 2);
        run_load(32'h0052, 1'b0, 1'b1, -1);
        scan(N * SD + 2);
        run_load(32'h0000, 1'b0, 1'b1, -1);
        scan(N * SD + 2);
        run_load(32'hFFFF, 1'b1, 1'b0, -1);
        scan(N * SD + 2);
        run_load(32'h1234, 1'b0, 1'b0, -1);
        scan(N * SD + 2);
        run_load(32'h4321, 1'b1, 1'b1, 5);
        scan(N * SD + 2);
        run_load(32'h0A07, 1'b0, 1'b0, 0);
        scan(N * SD + 2);
        run_load(32'd9999, 1'b1, 1'b0, -1);
        scan(N * SD);
        run_load(32'd10000, 1'b1, 1'b1, -1);
        scan(N * SD);

        for (int r = 0; r < 12; r++) begin
            run_load($urandom_range(0, 65535), 1'($urandom % 2), 1'($urandom % 2),
                     int'($urandom_range(0, 20)) - 4);
            scan(N * SD + int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a conversion with a stray Load while busy.
        run_load(32'h8888, 1'b0, 1'b0, -1);
        scan(N * SD);
        value = 16'd1234;
        dec   = 1'b1;
        blank = 1'b0;
        load  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            scan_check();
            load = (c == 2);
            if (c == 2) value = 16'h9999;
        end
        chk("busy_mid_convert", 32'(busy), 32'(1));
        do_reset();
        scan(2 * N * SD);
        chk("overflow_after_abort", 32'(ovf), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of display digits, range 2..8.
REQ-002 SHALL have parameter VALUE_WIDTH, default 16: input value width, range 4..4*NUM_DIGITS.
REQ-003 SHALL have parameter SCAN_DIV, default 1000: Clock cycles each digit is enabled, minimum 2.
REQ-004 Clock  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Value  input  VALUE_WIDTH  unsigned value to display.
REQ-007 Load  input  1  capture request for Value, DecimalMode and BlankLeading.
REQ-008 DecimalMode  input  1  1 = decimal digits, 0 = hex digits.
REQ-009 BlankLeading  input  1  1 = blank leading zero digits.
REQ-010 Busy  output  1  capture/conversion in progress; Load ignored while high.
REQ-011 Overflow  output  1  last decimal value needs more than NUM_DIGITS digits.
REQ-012 Segments  output  8  {dp,g,f,e,d,c,b,a}, active-high; dp always 0.
REQ-013 DigitEnable  output  NUM_DIGITS  one-hot, active-high; bit 0 = least significant digit.

Function
REQ-014 SHALL accept Load only when Busy=0 and Reset=0; Load while Busy=1 SHALL be ignored, not queued.
REQ-015 FSM states IDLE, CONVERT, COMMIT; IDLE->CONVERT on accepted Load if DecimalMode=1; IDLE->COMMIT if DecimalMode=0; CONVERT->COMMIT after exactly VALUE_WIDTH shift-add-3 (double-dabble) iterations; COMMIT->IDLE after one cycle.
REQ-016 Busy SHALL be 1 in CONVERT and COMMIT: 1 cycle for hex, VALUE_WIDTH+1 cycles for decimal.
REQ-017 Hex mode: digit i SHALL be Value[4i+3:4i], zero-extended above VALUE_WIDTH.
REQ-018 Decimal mode: digits SHALL be the low NUM_DIGITS BCD digits of Value; higher BCD digits discarded.
REQ-019 Overflow SHALL update in COMMIT: 1 if decimal and any discarded BCD digit non-zero, else 0.
REQ-020 Displayed digit register and captured BlankLeading SHALL update only in COMMIT; display holds old value during CONVERT.
REQ-021 Encoding 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex).
REQ-022 Prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index advances, wrapping NUM_DIGITS-1 -> 0.
REQ-023 Segments and DigitEnable SHALL be registered, reflecting the digit index one cycle late.
REQ-024 Blanking: with captured BlankLeading=1, every digit above the most significant non-zero digit SHALL output Segments=00; digit 0 is never blanked.
REQ-025 DigitEnable SHALL remain asserted for blanked digits (uniform scan timing).

Reset
REQ-026 Reset SHALL force: state IDLE, Busy=0, Overflow=0, Segments=00, DigitEnable=0, prescaler=0, digit index=0, digit register all zero, captured BlankLeading=0.
REQ-027 Reset during CONVERT SHALL abort the conversion; no partial result reaches the display.
REQ-028 First rising edge after Reset release SHALL give DigitEnable=...0001, Segments=3F.

Structure
REQ-029 Shared package seven_seg_pkg SHALL hold the FSM state enum and the 16-entry segment encoding constant table.
REQ-030 Sub-module seven_seg_encoder (4-bit digit in, 8-bit segments out, combinational) SHALL be the only encoding implementation.

Verification
REQ-031 Defaults, hex, no blank, Load Value=0x0052 -> Busy 1 cycle; digits 0..3 show 5B,6D,3F,3F; Overflow=0.
REQ-032 Decimal, Value=0x0052 (82) -> Busy exactly 17 cycles; digits 0..3 show 5B,7F,3F,3F.
REQ-033 BlankLeading=1, hex 0x0052 -> digits 2,3 Segments=00; then Value=0 -> digit 0 shows 3F, digits 1..3 show 00.
REQ-034 Decimal Value=0xFFFF (65535) -> Overflow=1, digits 0..3 show 6D,4F,6D,6D (5535); following hex load clears Overflow.
REQ-035 SCAN_DIV=4 -> DigitEnable 0001,0010,0100,1000,0001, each held exactly 4 cycles.
REQ-036 Reset pulse mid-CONVERT, plus Load pulsed while Busy -> Busy=0, display all 3F, ignored Load has no effect.
